// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - RV32I branch resolution with a 2-bit BHT predictor
// Resolves branches/jumps in execute, predicts at fetch, trains the table, and counts outcomes.
module branch_predict_unit #(
  parameter int          XLEN        = 32,
  parameter int          BHT_ENTRIES = 16,
  parameter int          IDX_W       = $clog2(BHT_ENTRIES),
  parameter int          CNT_W       = 32,
  parameter logic [6:0]  BOP         = 7'h63,
  parameter logic [6:0]  JALOP       = 7'h6F,
  parameter logic [6:0]  JALROP      = 7'h67
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [6:0]       opCode,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  operand1,
  input  logic [XLEN-1:0]  operand2,
  input  logic             ex_pred_taken,
  output logic             PCsrc,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_branch;
  logic             is_jump;
  logic             is_ctrl;
  logic             br_taken;
  logic             taken;
  logic             train;
  logic [1:0]       ctr_d;

  // Word-aligned PC bits select the counter; no tag, so aliasing is allowed.
  assign fetch_idx  = fetch_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign pred_taken = bht_q[fetch_idx][1];

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'd0:    br_taken = (operand1 == operand2);
      3'd1:    br_taken = (operand1 != operand2);
      3'd4:    br_taken = ($signed(operand1) <  $signed(operand2));
      3'd5:    br_taken = ($signed(operand1) >= $signed(operand2));
      3'd6:    br_taken = (operand1 <  operand2);
      3'd7:    br_taken = (operand1 >= operand2);
      default: br_taken = 1'b0;
    endcase
  end

  assign is_branch = (opCode == BOP) && (funct3 != 3'd2) && (funct3 != 3'd3);
  assign is_jump   = (opCode == JALOP) || (opCode == JALROP);
  assign is_ctrl   = ex_valid && (is_branch || is_jump);
  assign taken     = is_jump || br_taken;
  assign train     = ex_valid && is_branch;

  assign PCsrc      = !reset && is_ctrl && taken;
  assign mispredict = !reset && is_ctrl && (taken != ex_pred_taken);

  always_comb begin
    ctr_d = bht_q[ex_idx];
    if (br_taken) begin
      if (bht_q[ex_idx] != 2'b11) ctr_d = bht_q[ex_idx] + 2'b01;
    end else begin
      if (bht_q[ex_idx] != 2'b00) ctr_d = bht_q[ex_idx] - 2'b01;
    end
  end

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (is_ctrl && !(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (mispredict && !(&mp_cnt_q)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (train) bht_q[ex_idx] <= ctr_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mp_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
// A reference model pushes expected outputs per driven cycle; the checker pops them at negedge.
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [XLEN-1:0]  fetch_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [6:0]       opCode;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  operand1;
  logic [XLEN-1:0]  operand2;
  logic             ex_pred_taken;
  logic             PCsrc;
  logic             mispredict;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  branch_predict_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .opCode(opCode), .funct3(funct3),
    .operand1(operand1), .operand2(operand2), .ex_pred_taken(ex_pred_taken),
    .PCsrc(PCsrc), .mispredict(mispredict), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcsrc;
    logic        mis;
    logic        pred;
    logic [31:0] brc;
    logic [31:0] mpc;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  m_bht [16];
  int unsigned m_br, m_mp;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return !($signed(a) < $signed(b));
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_br = 0;
    m_mp = 0;
  endtask

  // Inputs are already driven; predict, compare at negedge, then advance the model at posedge.
  task automatic cycle(input string tag);
    exp_t e, g;
    logic br, jmp, ctrl, tk;
    int   idx;
    br   = (opCode == 7'h63) && (funct3 != 3'd2) && (funct3 != 3'd3);
    jmp  = (opCode == 7'h6F) || (opCode == 7'h67);
    ctrl = ex_valid && (br || jmp);
    tk   = jmp || ref_cond(funct3, operand1, operand2);
    e.pcsrc = !reset && ctrl && tk;
    e.mis   = !reset && ctrl && (tk != ex_pred_taken);
    e.pred  = m_bht[fetch_pc[5:2]][1];
    e.brc   = m_br;
    e.mpc   = m_mp;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check({tag, ".PCsrc"},      32'(PCsrc),         32'(g.pcsrc));
      check({tag, ".mispredict"}, 32'(mispredict),    32'(g.mis));
      check({tag, ".pred_taken"}, 32'(pred_taken),    32'(g.pred));
      check({tag, ".br_count"},   32'(br_count),      g.brc);
      check({tag, ".mp_count"},   32'(mispred_count), g.mpc);
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (ex_valid && br) begin
        idx = int'(ex_pc[5:2]);
        if (tk && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
        else if (!tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
      end
      if (ctrl && m_br < 15) m_br++;
      if (ctrl && (tk != ex_pred_taken) && m_mp < 15) m_mp++;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] op,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic pt, input logic [31:0] fpc);
    ex_valid = v; ex_pc = pc; opCode = op; funct3 = f3;
    operand1 = a; operand2 = b; ex_pred_taken = pt; fetch_pc = fpc;
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    cycle("rst_hold");
    reset = 1'b0;

    drive(1'b0, 32'h0, 7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    cycle("post_rst_pc0");
    fetch_pc = 32'h3C;
    cycle("post_rst_pc3c");

    drive(1'b1, 32'h8, 7'h63, 3'd0, 32'd5, 32'd5, 1'b0, 32'h8);
    cycle("beq_first");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8, 7'h63, 3'd0, 32'd5, 32'd5, 1'b1, 32'h8);
      cycle($sformatf("beq_taken%0d", i));
    end
    drive(1'b1, 32'h8, 7'h63, 3'd0, 32'd5, 32'd6, 1'b1, 32'h8);
    cycle("beq_not_taken");
    drive(1'b0, 32'h0, 7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h8);
    cycle("pc8_after");

    drive(1'b1, 32'h20, 7'h63, 3'd4, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h20);
    cycle("blt_neg");
    drive(1'b1, 32'h20, 7'h63, 3'd6, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h20);
    cycle("bltu_big");
    drive(1'b1, 32'h20, 7'h63, 3'd7, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h20);
    cycle("bgeu_big");
    drive(1'b1, 32'h24, 7'h63, 3'd5, 32'h1, 32'hFFFF_FFFF, 1'b0, 32'h24);
    cycle("bge_pos");
    drive(1'b1, 32'h24, 7'h63, 3'd1, 32'h7, 32'h7, 1'b0, 32'h24);
    cycle("bne_eq");

    drive(1'b1, 32'h28, 7'h6F, 3'd0, 32'h0, 32'h0, 1'b0, 32'h28);
    cycle("jal");
    drive(1'b1, 32'h28, 7'h67, 3'd0, 32'h0, 32'h0, 1'b1, 32'h28);
    cycle("jalr");
    drive(1'b1, 32'h28, 7'h63, 3'd2, 32'h0, 32'h0, 1'b0, 32'h28);
    cycle("bop_f3_2");
    drive(1'b1, 32'h28, 7'h33, 3'd0, 32'h0, 32'h0, 1'b1, 32'h28);
    cycle("alu_op");
    drive(1'b0, 32'h28, 7'h63, 3'd0, 32'h1, 32'h1, 1'b0, 32'h28);
    cycle("invalid_beq");

    drive(1'b1, 32'h10, 7'h63, 3'd0, 32'h3, 32'h3, 1'b0, 32'h10);
    cycle("same_idx_upd");
    drive(1'b0, 32'h0, 7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h10);
    cycle("same_idx_next");

    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h30, 7'h6F, 3'd0, 32'h0, 32'h0, 1'b0, 32'h30);
      cycle($sformatf("sat%0d", i));
    end
    drive(1'b0, 32'h0, 7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h8);
    cycle("sat_hold");

    reset = 1'b1;
    drive(1'b1, 32'h8, 7'h63, 3'd0, 32'h9, 32'h9, 1'b0, 32'h8);
    cycle("mid_reset");
    reset = 1'b0;
    drive(1'b0, 32'h0, 7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h8);
    cycle("after_mid_reset");
    fetch_pc = 32'h10;
    cycle("after_mid_reset_pc10");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
